// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO (TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4).
// Optional interrupt support is compiled in with `define UART_TX_IRQ_EN.
module uart_tx_mmio #(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_irq
);

  localparam int              DIV         = CLK_FREQ / BAUD;
  localparam int              CW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              PW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0]   CNT_MAX     = CW'(DIV - 1);
  localparam logic [PW:0]     CNT_FULL    = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          overflow, irq_en;
  logic          empty, full, busy, push_req, push_ok, pop, ovf_evt, status_rd, bit_end;
  logic          unused_bits;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign busy      = !empty || (state != IDLE);
  assign pop       = (state == IDLE) && !empty;
  assign push_req  = mem_write && (addr == BASE_ADDR);
  // A push into a full FIFO still lands when the same edge frees a slot.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_evt   = push_req && full && !pop;
  assign status_rd = mem_read && (addr == STATUS_ADDR);
  assign bit_end   = (baud_cnt == CNT_MAX);
  assign unused_bits = ^write_data[31:8];

  always_comb begin
    read_data = '0;
    if (status_rd) read_data = {27'b0, irq_en, overflow, empty, full, busy};
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
    if (pop) shreg <= fifo_mem[rd_ptr];
    else if ((state == DATA) && bit_end) shreg <= shreg >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop on the same edge as a STATUS read keeps the flag set.
      if (ovf_evt)        overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (!empty) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) irq_en <= 1'b0;
    else if (mem_write && (addr == STATUS_ADDR)) irq_en <= write_data[4];
  end

  assign tx_irq = irq_en && (state == STOP) && bit_end && empty;
`else
  assign irq_en = 1'b0;
  assign tx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic against a queue-based line model.
module tb_uart_tx_mmio;
  localparam int          DIV    = 16;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h4000_0018;
  localparam logic [31:0] STAT   = BASE + 32'd4;

  logic        clk, rst, mem_read, mem_write;
  logic [31:0] addr, write_data, read_data;
  logic        tx, tx_irq;

  int n_cmp = 0;
  int n_fail = 0;

  uart_tx_mmio #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .tx(tx), .tx_irq(tx_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line model: queued bytes, and the frame currently on the wire with its cycle position.
  logic [7:0] q[$];
  logic [9:0] m_frame;
  int         m_pos;
  bit         m_active, m_ovf, m_irq_en, m_valid;
  bit         m_push, m_pop, m_evt;

  initial begin
    m_valid = 0; m_active = 0; m_pos = 0; m_ovf = 0; m_irq_en = 0; m_frame = '0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_active = 0; m_pos = 0; m_ovf = 0; m_irq_en = 0; m_valid = 1;
    end else if (m_valid) begin
      m_push = mem_write && (addr == BASE);
      m_pop  = !m_active && (q.size() != 0);
      m_evt  = m_push && (q.size() == DEPTH) && !m_pop;
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * DIV) begin
          m_active = 0;
          m_pos = 0;
        end
      end else if (m_pop) begin
        m_frame  = {1'b1, q.pop_front(), 1'b0};
        m_active = 1;
        m_pos    = 0;
      end
      if (m_push && !m_evt) q.push_back(write_data[7:0]);
      if (m_evt) m_ovf = 1;
      else if (mem_read && (addr == STAT)) m_ovf = 0;
`ifdef UART_TX_IRQ_EN
      if (mem_write && (addr == STAT)) m_irq_en = write_data[4];
`endif
    end
  end

  function automatic logic exp_tx();
    return m_active ? m_frame[m_pos / DIV] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic busy;
    busy = (q.size() != 0) || m_active;
    if (mem_read && (addr == STAT))
      return {27'b0, m_irq_en, m_ovf, (q.size() == 0), (q.size() == DEPTH), busy};
    return 32'h0;
  endfunction

  function automatic logic exp_irq();
`ifdef UART_TX_IRQ_EN
    return m_active && (m_pos == 10 * DIV - 1) && m_irq_en && (q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx_cycle", {31'b0, tx}, {31'b0, exp_tx()});
      check("irq_cycle", {31'b0, tx_irq}, {31'b0, exp_irq()});
      check("rdata_cycle", read_data, exp_rdata());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    mem_read = 1'b1;
    addr = STAT;
    #1;
    check(name, read_data, exp);
    mem_read = 1'b0;
  endtask

  int g, irq_cnt;
  logic [31:0] irq_exp, stat_exp;

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("reset_tx", {31'b0, tx}, 32'h1);
    #1 check("reset_rdata_noread", read_data, 32'h0);
    read_status("reset_status", 32'h4);

    // Single byte 0xA5.
    mem_write = 1'b1; addr = BASE; write_data = 32'hA5;
    tick();
    mem_write = 1'b0;
    check("pre_start_tx", {31'b0, tx}, 32'h1);
    tick();
    check("start_tx", {31'b0, tx}, 32'h0);
    check("model_frame", {22'b0, m_frame}, 32'h34A);
    read_status("busy_status", 32'h5);
    repeat (DIV) tick();
    check("a5_bit0", {31'b0, tx}, 32'h1);
    repeat (DIV) tick();
    check("a5_bit1", {31'b0, tx}, 32'h0);
    repeat (DIV * 7) tick();
    check("a5_stop", {31'b0, tx}, 32'h1);
    read_status("stop_status", 32'h5);
    repeat (DIV) tick();
    read_status("done_status", 32'h4);

    // Six back-to-back stores: one pops immediately, four queue, the last drops.
    for (int i = 0; i < 6; i++) begin
      mem_write = 1'b1; addr = BASE; write_data = 32'h11 + i;
      tick();
    end
    mem_write = 1'b0;
    mem_read = 1'b1; addr = STAT;
    #1 check("ovf_status", read_data, 32'hB);
    tick();
    check("ovf_cleared", read_data, 32'h3);
    mem_read = 1'b0;

    // Store while full on the cycle the FSM pops.
    g = 0;
    while (m_active && g < 400) begin
      tick();
      g++;
    end
    check("idle_wait_bound", {31'b0, (g < 400)}, 32'h1);
    mem_write = 1'b1; addr = BASE; write_data = 32'h77;
    tick();
    mem_write = 1'b0;
    read_status("pop_push_status", 32'h3);

    // Reset in the middle of data bit 3.
    g = 0;
    while (!(m_active && m_pos == DIV * 4 + 3) && g < 400) begin
      tick();
      g++;
    end
    check("bit3_wait_bound", {31'b0, (g < 400)}, 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_tx", {31'b0, tx}, 32'h1);
    read_status("midreset_status", 32'h4);

    // Interrupt enable and a single 0x00 frame.
    mem_write = 1'b1; addr = STAT; write_data = 32'h10;
    tick();
    addr = BASE; write_data = 32'h00;
    tick();
    mem_write = 1'b0;
    irq_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_irq === 1'b1) irq_cnt++;
    end
`ifdef UART_TX_IRQ_EN
    irq_exp = 32'd1; stat_exp = 32'h14;
`else
    irq_exp = 32'd0; stat_exp = 32'h4;
`endif
    check("irq_pulses", irq_cnt, irq_exp);
    read_status("irq_status", stat_exp);

    // Random bus traffic.
    for (int i = 0; i < 6000; i++) begin
      mem_write  = ($urandom_range(0, 19) == 0);
      mem_read   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: addr = BASE;
        3:       addr = STAT;
        4:       addr = BASE + 32'd8;
        default: addr = $urandom;
      endcase
      write_data = $urandom;
      rst = ($urandom_range(0, 2999) != 0);
      tick();
    end
    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
